tap_top: RTL and testbench
==========================

TAP_TOP -- requirements
Module: tap_top

Interface
REQ-001 The module SHALL have parameter IDCODE_VALUE, default 32'h149511C3, the 32-bit device ID returned by IDCODE.
REQ-002 The module SHALL have port tck_pad_i, input, 1 bit: the test clock, and the only clock.
REQ-003 The module SHALL have port trst_pad_i, input, 1 bit: the test reset, asynchronous and active-low.
REQ-004 The module SHALL have port tms_pad_i, input, 1 bit: test mode select, sampled on the tck rising edge.
REQ-005 The module SHALL have port tdi_pad_i, input, 1 bit: serial test data in, sampled on the tck rising edge.
REQ-006 The module SHALL have port tdo_pad_o, output, 1 bit: serial test data out, registered on the tck falling edge.

Function
REQ-007 The TAP FSM SHALL implement the 16 IEEE 1149.1 states, with state updated on the tck rising edge according to tms_pad_i.
REQ-008 FSM transitions, given as state: next-state when tms=0 / when tms=1, SHALL be:
- TLR: RTI / TLR
- RTI: RTI / SelDR
- SelDR: CapDR / SelIR
- CapDR: ShDR / Ex1DR
- ShDR: ShDR / Ex1DR
- Ex1DR: PauseDR / UpdDR
- PauseDR: PauseDR / Ex2DR
- Ex2DR: ShDR / UpdDR
- UpdDR: RTI / SelDR
- SelIR: CapIR / TLR
- The IR column (CapIR … UpdIR) SHALL mirror the DR column, including UpdIR: RTI / SelDR.
REQ-009 Five consecutive rising edges with tms=1 SHALL reach TLR from any state.
REQ-010 The instruction register SHALL be 4 bits wide.
REQ-011 In CapIR, the instruction shift register SHALL load 4'b0101.
REQ-012 In ShIR, on each rising edge the instruction shift register SHALL shift right with tdi entering bit 3.
REQ-013 On the tck falling edge while in UpdIR, the instruction shift register contents SHALL be copied into the latched instruction.
REQ-014 The latched instruction SHALL be IDCODE (4'b0010) while in TLR and after reset.
REQ-015 Decoded instructions SHALL be:
- 4'b0010 IDCODE
- 4'b1111 BYPASS
- 4'b0000 EXTEST, 4'b0001 SAMPLE_PRELOAD, 4'b1000 DEBUG, 4'b1001 MBIST, and all other codes SHALL select the bypass register.
REQ-016 IDCODE register: 32 bits; in CapDR it SHALL load IDCODE_VALUE; in ShDR it SHALL shift right with tdi entering bit 31.
REQ-017 Bypass register: 1 bit; in CapDR it SHALL load 0; in ShDR it SHALL load tdi.
REQ-018 Only the data register selected by the latched instruction SHALL capture or shift; the others SHALL hold.
REQ-019 On each tck falling edge, tdo_pad_o SHALL be set to:
- IR shift register bit 0, in ShIR;
- the selected data register bit 0, in ShDR;
- 0, in all other states.
REQ-020 Bits SHALL be shifted LSB first, so the first bit appears on tdo half a tck cycle after ShDR or ShIR is entered.
REQ-021 A shift exited through Ex1 with tms=1 on the last bit SHALL still shift that final bit.
REQ-022 Pause states SHALL hold register contents.
REQ-023 The Update states SHALL NOT alter any data register.

Reset
REQ-024 While trst_pad_i=0, the following SHALL be forced immediately, independent of tck:
- state = TLR
- instruction shift register = 0
- latched instruction = IDCODE
- bypass = 0
- IDCODE register = IDCODE_VALUE
- tdo_pad_o = 0
REQ-025 Asserting reset mid-shift SHALL abort the operation with no update of the latched instruction.
REQ-026 After reset release, the FSM SHALL leave TLR only on the first rising edge with tms=0.

Verification
REQ-027 Reset scenario: pulse trst=0, then tms=1 for 5 cycles -> state TLR, tdo=0, latched instruction 4'b0010.
REQ-028 Arbitrary-state escape: tms 1,1,0,1,0,0 then 1,1,1,1,1 -> state TLR from any intermediate state.
REQ-029 IR load: from TLR, tms 0,1,1,0,0 (ShIR), then shift tdi 1,1,1,1 with tms=1 on the last bit, then tms=1 (UpdIR) ->
- tdo = 1,0,1,0 during the shift;
- latched instruction = 4'b1111.
REQ-030 BYPASS data: after REQ-029, tms 1,0,0 (ShDR), then tdi 0,1,0,1,0,1,0,0,1 -> tdo = 0 (captured bypass), then tdi delayed by one tck cycle.
REQ-031 IDCODE: after reset, tms 0,1,0,0 (ShDR), then 32 shifts -> tdo = 32'h149511C3, LSB first.
REQ-032 Reset mid-shift: assert trst during ShIR -> state TLR and latched instruction = IDCODE immediately.

Source files
------------

// File: rtl/tap_top.sv
// IEEE 1149.1 TAP controller: 16-state FSM, 4-bit IR, IDCODE and BYPASS data registers.
// Shift, capture and state updates happen on tck rise; the IR latch and tdo update on tck fall.
module tap_top #(
    parameter logic [31:0] IDCODE_VALUE = 32'h149511C3
) (
    input  logic tck_pad_i,
    input  logic trst_pad_i,
    input  logic tms_pad_i,
    input  logic tdi_pad_i,
    output logic tdo_pad_o
);

    // state    | meaning
    // TLR      | test-logic-reset, IR latched to IDCODE
    // RTI      | run-test/idle
    // SEL_xR   | select DR / IR column
    // CAP_xR   | capture into the DR / IR shift register
    // SH_xR    | shift one bit per tck, LSB out on tdo
    // EX1/EX2  | exit states around the pause
    // PAUSE_xR | hold shift register contents
    // UPD_xR   | update; IR latched on the falling edge of UPD_IR
    typedef enum logic [3:0] {
        TLR      = 4'd0,
        RTI      = 4'd1,
        SEL_DR   = 4'd2,
        CAP_DR   = 4'd3,
        SH_DR    = 4'd4,
        EX1_DR   = 4'd5,
        PAUSE_DR = 4'd6,
        EX2_DR   = 4'd7,
        UPD_DR   = 4'd8,
        SEL_IR   = 4'd9,
        CAP_IR   = 4'd10,
        SH_IR    = 4'd11,
        EX1_IR   = 4'd12,
        PAUSE_IR = 4'd13,
        EX2_IR   = 4'd14,
        UPD_IR   = 4'd15
    } tap_state_t;

    localparam logic [3:0] IR_IDCODE  = 4'b0010;
    localparam logic [3:0] IR_CAPTURE = 4'b0101;

    tap_state_t  r_state;
    logic [3:0]  r_ir_sr;
    logic [3:0]  r_latched_ir;
    logic        r_bypass;
    logic [31:0] r_idcode_sr;
    logic        r_tdo;
    logic        w_sel_idcode;

    // Every code other than IDCODE routes through the bypass register.
    assign w_sel_idcode = (r_latched_ir == IR_IDCODE);
    assign tdo_pad_o    = r_tdo;

    always_ff @(posedge tck_pad_i or negedge trst_pad_i) begin
        if (!trst_pad_i) begin
            r_state <= TLR;
        end else begin
            case (r_state)
                TLR:      r_state <= tms_pad_i ? TLR      : RTI;
                RTI:      r_state <= tms_pad_i ? SEL_DR   : RTI;
                SEL_DR:   r_state <= tms_pad_i ? SEL_IR   : CAP_DR;
                CAP_DR:   r_state <= tms_pad_i ? EX1_DR   : SH_DR;
                SH_DR:    r_state <= tms_pad_i ? EX1_DR   : SH_DR;
                EX1_DR:   r_state <= tms_pad_i ? UPD_DR   : PAUSE_DR;
                PAUSE_DR: r_state <= tms_pad_i ? EX2_DR   : PAUSE_DR;
                EX2_DR:   r_state <= tms_pad_i ? UPD_DR   : SH_DR;
                UPD_DR:   r_state <= tms_pad_i ? SEL_DR   : RTI;
                SEL_IR:   r_state <= tms_pad_i ? TLR      : CAP_IR;
                CAP_IR:   r_state <= tms_pad_i ? EX1_IR   : SH_IR;
                SH_IR:    r_state <= tms_pad_i ? EX1_IR   : SH_IR;
                EX1_IR:   r_state <= tms_pad_i ? UPD_IR   : PAUSE_IR;
                PAUSE_IR: r_state <= tms_pad_i ? EX2_IR   : PAUSE_IR;
                EX2_IR:   r_state <= tms_pad_i ? UPD_IR   : SH_IR;
                UPD_IR:   r_state <= tms_pad_i ? SEL_DR   : RTI;
                default:  r_state <= TLR;
            endcase
        end
    end

    always_ff @(posedge tck_pad_i or negedge trst_pad_i) begin
        if (!trst_pad_i) begin
            r_ir_sr     <= 4'b0000;
            r_bypass    <= 1'b0;
            r_idcode_sr <= IDCODE_VALUE;
        end else begin
            case (r_state)
                CAP_IR: r_ir_sr <= IR_CAPTURE;
                SH_IR:  r_ir_sr <= {tdi_pad_i, r_ir_sr[3:1]};
                CAP_DR: begin
                    if (w_sel_idcode) r_idcode_sr <= IDCODE_VALUE;
                    else              r_bypass    <= 1'b0;
                end
                SH_DR: begin
                    if (w_sel_idcode) r_idcode_sr <= {tdi_pad_i, r_idcode_sr[31:1]};
                    else              r_bypass    <= tdi_pad_i;
                end
                default: ;
            endcase
        end
    end

    always_ff @(negedge tck_pad_i or negedge trst_pad_i) begin
        if (!trst_pad_i) begin
            r_latched_ir <= IR_IDCODE;
            r_tdo        <= 1'b0;
        end else begin
            if (r_state == TLR)         r_latched_ir <= IR_IDCODE;
            else if (r_state == UPD_IR) r_latched_ir <= r_ir_sr;
            case (r_state)
                SH_IR:   r_tdo <= r_ir_sr[0];
                SH_DR:   r_tdo <= w_sel_idcode ? r_idcode_sr[0] : r_bypass;
                default: r_tdo <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_tap_top.sv
// Self-checking bench for tap_top: FSM walk against a transition model, IR load,
// BYPASS and IDCODE shifting through a tdo scoreboard, and asynchronous reset.
module tb_tap_top;

    localparam logic [31:0] IDV = 32'h149511C3;

    localparam logic [3:0] S_TLR = 4'd0,  S_RTI = 4'd1,  S_SEL_DR = 4'd2,  S_CAP_DR = 4'd3;
    localparam logic [3:0] S_SH_DR = 4'd4, S_EX1_DR = 4'd5, S_PAUSE_DR = 4'd6, S_EX2_DR = 4'd7;
    localparam logic [3:0] S_UPD_DR = 4'd8, S_SEL_IR = 4'd9, S_CAP_IR = 4'd10, S_SH_IR = 4'd11;
    localparam logic [3:0] S_EX1_IR = 4'd12, S_PAUSE_IR = 4'd13, S_EX2_IR = 4'd14, S_UPD_IR = 4'd15;

    logic tck    = 1'b0;
    logic trst_n = 1'b1;
    logic tms    = 1'b1;
    logic tdi    = 1'b0;
    logic tdo;

    int n_checks = 0;
    int n_fail   = 0;
    logic q_exp[$];

    tap_top #(.IDCODE_VALUE(IDV)) dut (
        .tck_pad_i (tck),
        .trst_pad_i(trst_n),
        .tms_pad_i (tms),
        .tdi_pad_i (tdi),
        .tdo_pad_o (tdo)
    );

    always #5 tck = ~tck;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got no summary, required finish");
        $fatal(1);
    end

    function automatic logic [3:0] model_next(input logic [3:0] s, input logic t);
        case (s)
            S_TLR:      return t ? S_TLR    : S_RTI;
            S_RTI:      return t ? S_SEL_DR : S_RTI;
            S_SEL_DR:   return t ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR:   return t ? S_EX1_DR : S_SH_DR;
            S_SH_DR:    return t ? S_EX1_DR : S_SH_DR;
            S_EX1_DR:   return t ? S_UPD_DR : S_PAUSE_DR;
            S_PAUSE_DR: return t ? S_EX2_DR : S_PAUSE_DR;
            S_EX2_DR:   return t ? S_UPD_DR : S_SH_DR;
            S_UPD_DR:   return t ? S_SEL_DR : S_RTI;
            S_SEL_IR:   return t ? S_TLR    : S_CAP_IR;
            S_CAP_IR:   return t ? S_EX1_IR : S_SH_IR;
            S_SH_IR:    return t ? S_EX1_IR : S_SH_IR;
            S_EX1_IR:   return t ? S_UPD_IR : S_PAUSE_IR;
            S_PAUSE_IR: return t ? S_EX2_IR : S_PAUSE_IR;
            S_EX2_IR:   return t ? S_UPD_IR : S_SH_IR;
            default:    return t ? S_SEL_DR : S_RTI;
        endcase
    endfunction

    // Drive inputs, take one tck period, and sample just after the falling edge.
    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    task automatic pulse_reset();
        trst_n = 1'b0;
        #2;
        trst_n = 1'b1;
        step(1'b1, 1'b0);
    endtask

    // From TLR/RTI/Update: load code into IR and stop in UPD_IR.
    task automatic load_ir(input logic [3:0] code);
        step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 4; i++) step(i == 3, code[i]);
        step(1, 0);
    endtask

    task automatic test_reset();
        logic [3:0] st;
        step(0, 0); step(1, 0); step(0, 0); step(0, 0);
        step(0, 0); step(0, 0);
        #2;
        trst_n = 1'b0;
        #1;
        st = dut.r_state;
        n_checks++; if (st !== S_TLR) begin n_fail++; $display("FAIL reset_state: got %0d required %0d", st, S_TLR); end
        n_checks++; if (dut.r_latched_ir !== 4'b0010) begin n_fail++; $display("FAIL reset_ir_latch: got %b required 0010", dut.r_latched_ir); end
        n_checks++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL reset_tdo: got %b required 0", tdo); end
        n_checks++; if (dut.r_ir_sr !== 4'b0000) begin n_fail++; $display("FAIL reset_ir_sr: got %b required 0000", dut.r_ir_sr); end
        n_checks++; if (dut.r_bypass !== 1'b0) begin n_fail++; $display("FAIL reset_bypass: got %b required 0", dut.r_bypass); end
        n_checks++; if (dut.r_idcode_sr !== IDV) begin n_fail++; $display("FAIL reset_idcode_sr: got %h required %h", dut.r_idcode_sr, IDV); end
        tms = 1'b0;
        @(posedge tck); @(posedge tck); @(negedge tck); #1;
        st = dut.r_state;
        n_checks++; if (st !== S_TLR) begin n_fail++; $display("FAIL reset_hold_state: got %0d required %0d", st, S_TLR); end
        trst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1, 0);
        st = dut.r_state;
        n_checks++; if (st !== S_TLR) begin n_fail++; $display("FAIL tms5_state: got %0d required %0d", st, S_TLR); end
        n_checks++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL tms5_tdo: got %b required 0", tdo); end
        n_checks++; if (dut.r_latched_ir !== 4'b0010) begin n_fail++; $display("FAIL tms5_ir_latch: got %b required 0010", dut.r_latched_ir); end
        step(0, 0);
        st = dut.r_state;
        n_checks++; if (st !== S_RTI) begin n_fail++; $display("FAIL leave_tlr: got %0d required %0d", st, S_RTI); end
    endtask

    task automatic test_escape();
        logic [0:10] pat;
        logic [3:0]  m;
        logic [3:0]  st;
        logic        t;
        int          len;
        pulse_reset();
        m   = S_TLR;
        pat = 11'b11010011111;
        for (int i = 0; i < 11; i++) begin
            step(pat[i], 0);
            m  = model_next(m, pat[i]);
            st = dut.r_state;
            n_checks++; if (st !== m) begin n_fail++; $display("FAIL escape_seq[%0d]: got %0d required %0d", i, st, m); end
        end
        for (int r = 0; r < 10; r++) begin
            len = $urandom_range(1, 14);
            for (int k = 0; k < len; k++) begin
                t = 1'($urandom_range(0, 1));
                step(t, 1'($urandom_range(0, 1)));
                m  = model_next(m, t);
                st = dut.r_state;
                n_checks++; if (st !== m) begin n_fail++; $display("FAIL walk_state r%0d k%0d: got %0d required %0d", r, k, st, m); end
                if (m != S_SH_DR && m != S_SH_IR) begin
                    n_checks++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL walk_tdo r%0d k%0d: got %b required 0", r, k, tdo); end
                end
            end
            for (int k = 0; k < 5; k++) step(1, 0);
            m  = S_TLR;
            st = dut.r_state;
            n_checks++; if (st !== S_TLR) begin n_fail++; $display("FAIL escape_5tms r%0d: got %0d required %0d", r, st, S_TLR); end
        end
    endtask

    task automatic test_ir_load_and_bypass();
        logic [0:8] pat;
        logic       e;
        logic [3:0] st;
        pulse_reset();
        step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        st = dut.r_state;
        n_checks++; if (st !== S_SH_IR) begin n_fail++; $display("FAIL ir_enter_shift: got %0d required %0d", st, S_SH_IR); end
        q_exp.push_back(1'b1); q_exp.push_back(1'b0); q_exp.push_back(1'b1); q_exp.push_back(1'b0);
        for (int i = 0; i < 4; i++) begin
            e = q_exp.pop_front();
            n_checks++; if (tdo !== e) begin n_fail++; $display("FAIL ir_tdo[%0d]: got %b required %b", i, tdo, e); end
            step(i == 3, 1'b1);
        end
        st = dut.r_state;
        n_checks++; if (st !== S_EX1_IR) begin n_fail++; $display("FAIL ir_exit: got %0d required %0d", st, S_EX1_IR); end
        n_checks++; if (dut.r_ir_sr !== 4'b1111) begin n_fail++; $display("FAIL ir_last_bit: got %b required 1111", dut.r_ir_sr); end
        n_checks++; if (dut.r_latched_ir !== 4'b0010) begin n_fail++; $display("FAIL ir_latch_early: got %b required 0010", dut.r_latched_ir); end
        step(1, 0);
        n_checks++; if (dut.r_latched_ir !== 4'b1111) begin n_fail++; $display("FAIL ir_latch: got %b required 1111", dut.r_latched_ir); end
        step(1, 0); step(0, 0); step(0, 0);
        pat = 9'b010101001;
        q_exp.push_back(1'b0);
        for (int i = 0; i < 9; i++) begin
            e = q_exp.pop_front();
            n_checks++; if (tdo !== e) begin n_fail++; $display("FAIL bypass_tdo[%0d]: got %b required %b", i, tdo, e); end
            q_exp.push_back(pat[i]);
            step(0, pat[i]);
        end
        e = q_exp.pop_front();
        n_checks++; if (tdo !== e) begin n_fail++; $display("FAIL bypass_tdo[9]: got %b required %b", tdo, e); end
        n_checks++; if (dut.r_idcode_sr !== IDV) begin n_fail++; $display("FAIL bypass_idcode_hold: got %h required %h", dut.r_idcode_sr, IDV); end
        step(1, 0);
        n_checks++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL bypass_exit_tdo: got %b required 0", tdo); end
    endtask

    task automatic test_idcode();
        logic [31:0] sh_in;
        logic        e;
        logic [3:0]  st;
        pulse_reset();
        sh_in = $urandom();
        step(0, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 32; i++) q_exp.push_back(IDV[i]);
        for (int i = 0; i < 32; i++) begin
            e = q_exp.pop_front();
            n_checks++; if (tdo !== e) begin n_fail++; $display("FAIL idcode_tdo[%0d]: got %b required %b", i, tdo, e); end
            step(i == 31, sh_in[i]);
        end
        st = dut.r_state;
        n_checks++; if (st !== S_EX1_DR) begin n_fail++; $display("FAIL idcode_exit: got %0d required %0d", st, S_EX1_DR); end
        n_checks++; if (dut.r_idcode_sr !== sh_in) begin n_fail++; $display("FAIL idcode_shift_in: got %h required %h", dut.r_idcode_sr, sh_in); end
        for (int i = 0; i < 3; i++) step(0, ~tdi);
        n_checks++; if (dut.r_idcode_sr !== sh_in) begin n_fail++; $display("FAIL pause_hold: got %h required %h", dut.r_idcode_sr, sh_in); end
        step(1, 1); step(1, 1);
        st = dut.r_state;
        n_checks++; if (st !== S_UPD_DR) begin n_fail++; $display("FAIL upd_dr_state: got %0d required %0d", st, S_UPD_DR); end
        n_checks++; if (dut.r_idcode_sr !== sh_in) begin n_fail++; $display("FAIL update_hold: got %h required %h", dut.r_idcode_sr, sh_in); end
        step(1, 0); step(0, 0); step(0, 0);
        n_checks++; if (tdo !== IDV[0]) begin n_fail++; $display("FAIL idcode_recapture: got %b required %b", tdo, IDV[0]); end
    endtask

    task automatic test_decode();
        logic [3:0] codes [6];
        logic [0:2] seq;
        logic       e;
        codes = '{4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b0110, 4'b0010};
        for (int c = 0; c < 6; c++) begin
            pulse_reset();
            load_ir(codes[c]);
            n_checks++; if (dut.r_latched_ir !== codes[c]) begin n_fail++; $display("FAIL decode_latch %b: got %b", codes[c], dut.r_latched_ir); end
            step(1, 0); step(0, 0); step(0, 0);
            if (codes[c] == 4'b0010) seq = {IDV[0], IDV[1], IDV[2]};
            else                     seq = 3'b010;
            for (int i = 0; i < 3; i++) q_exp.push_back(seq[i]);
            for (int i = 0; i < 3; i++) begin
                e = q_exp.pop_front();
                n_checks++; if (tdo !== e) begin n_fail++; $display("FAIL decode_tdo %b[%0d]: got %b required %b", codes[c], i, tdo, e); end
                step(0, i == 0);
            end
            if (codes[c] != 4'b0010) begin
                n_checks++; if (dut.r_idcode_sr !== IDV) begin n_fail++; $display("FAIL decode_idcode_hold %b: got %h required %h", codes[c], dut.r_idcode_sr, IDV); end
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [3:0] st;
        pulse_reset();
        load_ir(4'b1111);
        n_checks++; if (dut.r_latched_ir !== 4'b1111) begin n_fail++; $display("FAIL midrst_pre_latch: got %b required 1111", dut.r_latched_ir); end
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        step(0, 1); step(0, 0);
        #2;
        trst_n = 1'b0;
        #1;
        st = dut.r_state;
        n_checks++; if (st !== S_TLR) begin n_fail++; $display("FAIL midrst_state: got %0d required %0d", st, S_TLR); end
        n_checks++; if (dut.r_latched_ir !== 4'b0010) begin n_fail++; $display("FAIL midrst_latch: got %b required 0010", dut.r_latched_ir); end
        n_checks++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL midrst_tdo: got %b required 0", tdo); end
        trst_n = 1'b1;
        step(1, 0); step(1, 0);
        n_checks++; if (dut.r_latched_ir !== 4'b0010) begin n_fail++; $display("FAIL midrst_after: got %b required 0010", dut.r_latched_ir); end
    endtask

    initial begin
        #2 trst_n = 1'b0;
        #2 trst_n = 1'b1;
        @(negedge tck);
        #1;
        test_reset();
        test_escape();
        test_ir_load_and_bypass();
        test_idcode();
        test_decode();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
